// File: rtl/prog_sequencer.sv
// Batch run controller: pulses the core's Start for each program in turn,
// times each run until Ack, aborts a run that exceeds TIMEOUT cycles.
module prog_sequencer #(
    parameter int NPROG     = 3,
    parameter int PW        = 2,
    parameter int START_CYC = 2,
    parameter int CW        = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Go,
    input  logic          Ack,
    output logic          Start,
    output logic [PW-1:0] ProgIdx,
    output logic          Busy,
    output logic          Done,
    output logic          Timeout,
    output logic [CW-1:0] CycleCt
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN} state_t;

    localparam logic [CW-1:0] START_LAST = CW'(START_CYC - 1);
    localparam logic [CW-1:0] TO_VAL     = CW'(TIMEOUT);
    localparam logic [PW-1:0] LAST_PROG  = PW'(NPROG - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          start_q, start_d;
    logic [PW-1:0] prog_q, prog_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;
    logic [CW-1:0] cyc_q, cyc_d;

    // cnt never reaches all-ones in RUN because the abort fires at TIMEOUT-1
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start_d   = start_q;
        prog_d    = prog_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        cyc_d     = cyc_q;

        case (state_q)
            S_IDLE: begin
                start_d = 1'b0;
                busy_d  = 1'b0;
                if (Go) begin
                    state_d   = S_START;
                    prog_d    = '0;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    start_d   = 1'b1;
                end
            end
            S_START: begin
                // Ack is deliberately ignored here: it may still be high from the previous run
                if (cnt_q == START_LAST) begin
                    state_d = S_RUN;
                    start_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RUN: begin
                cnt_d = cnt_inc;
                if (Ack) begin
                    cyc_d = cnt_inc;
                    if (prog_q == LAST_PROG) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        prog_d  = prog_q + 1'b1;
                        state_d = S_START;
                        start_d = 1'b1;
                        cnt_d   = '0;
                    end
                end else if (cnt_inc == TO_VAL) begin
                    cyc_d     = TO_VAL;
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            prog_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            cyc_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            prog_q    <= prog_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            cyc_q     <= cyc_d;
        end
    end

    assign Start   = start_q;
    assign ProgIdx = prog_q;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Timeout = timeout_q;
    assign CycleCt = cyc_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: a scripted core model plays out each batch as a
// timeline of Start/RUN/Done cycles and compares every cycle's outputs.
module tb_prog_sequencer;

    localparam int NPROG     = 3;
    localparam int PW        = 2;
    localparam int START_CYC = 2;
    localparam int CW        = 16;
    localparam int TIMEOUT   = 64;
    localparam int VW        = 4 + PW + CW;

    logic          Clk = 1'b0;
    logic          Reset, Go, Ack;
    logic          Start, Busy, Done, Timeout;
    logic [PW-1:0] ProgIdx;
    logic [CW-1:0] CycleCt;

    prog_sequencer #(
        .NPROG(NPROG), .PW(PW), .START_CYC(START_CYC), .CW(CW), .TIMEOUT(TIMEOUT)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Go(Go), .Ack(Ack), .Start(Start),
        .ProgIdx(ProgIdx), .Busy(Busy), .Done(Done), .Timeout(Timeout),
        .CycleCt(CycleCt)
    );

    always #5 Clk = ~Clk;

    wire [VW-1:0] obs_v = {Start, Busy, Done, Timeout, ProgIdx, CycleCt};

    int checks = 0;
    int errors = 0;

    // Reference state as the harness sees it between cycles
    logic          m_to, m_done;
    logic [PW-1:0] m_prog;
    logic [CW-1:0] m_cyc;
    bit            ack_hi = 1'b0;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_cycles(input int n, input bit ack_noise);
        logic [VW-1:0] exp_v;
        for (int i = 0; i < n; i++) begin
            exp_v = {1'b0, 1'b0, m_done, m_to, m_prog, m_cyc};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL idle[%0d]: got %h want %h", i, obs_v, exp_v);
            end
            Go  = 1'b0;
            Ack = ack_noise ? 1'($urandom_range(1, 0)) : 1'b0;
            step();
            m_done = 1'b0;
        end
    endtask

    // lat = RUN cycle on which the core acks (0 or >TIMEOUT: never).
    // rst_p/rst_k: assert Reset on RUN cycle rst_k of program rst_p (rst_p<0: never).
    task automatic run_batch(input int l0, input int l1, input int l2,
                             input bit go_hold, input int rst_p, input int rst_k);
        int            lat [3];
        bit            stop;
        logic [VW-1:0] exp_v;
        lat[0] = l0; lat[1] = l1; lat[2] = l2;
        stop = 1'b0;

        exp_v = {1'b0, 1'b0, m_done, m_to, m_prog, m_cyc};
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL accept: got %h want %h", obs_v, exp_v);
        end
        Go  = 1'b1;
        Ack = 1'($urandom_range(1, 0));
        step();
        m_done = 1'b0;
        m_to   = 1'b0;

        for (int p = 0; p < NPROG; p++) begin
            m_prog = PW'(p);
            for (int s = 0; s < START_CYC; s++) begin
                exp_v = {1'b1, 1'b1, 1'b0, 1'b0, m_prog, m_cyc};
                checks++;
                if (obs_v !== exp_v) begin
                    errors++;
                    $display("FAIL start p%0d s%0d: got %h want %h", p, s, obs_v, exp_v);
                end
                Go  = go_hold ? 1'b1 : 1'($urandom_range(1, 0));
                Ack = ack_hi ? 1'b1 : 1'($urandom_range(1, 0));
                step();
            end
            for (int k = 1; k <= TIMEOUT; k++) begin
                exp_v = {1'b0, 1'b1, 1'b0, 1'b0, m_prog, m_cyc};
                checks++;
                if (obs_v !== exp_v) begin
                    errors++;
                    $display("FAIL run p%0d k%0d: got %h want %h", p, k, obs_v, exp_v);
                end
                if (p == rst_p && k == rst_k) begin
                    Reset = 1'b1; Go = 1'b1; Ack = 1'b1;
                    step();
                    Reset = 1'b0; Go = 1'b0; Ack = 1'b0;
                    m_prog = '0; m_cyc = '0; m_to = 1'b0; m_done = 1'b0;
                    exp_v = '0;
                    checks++;
                    if (obs_v !== exp_v) begin
                        errors++;
                        $display("FAIL reset_mid_run: got %h want %h", obs_v, exp_v);
                    end
                    stop = 1'b1;
                    break;
                end
                Go  = go_hold ? 1'b1 : 1'($urandom_range(1, 0));
                Ack = (k == lat[p]);
                if (k == lat[p]) begin
                    m_cyc = CW'(k);
                    step();
                    if (p == NPROG - 1) m_done = 1'b1;
                    break;
                end
                if (k == TIMEOUT) begin
                    m_cyc  = CW'(TIMEOUT);
                    m_to   = 1'b1;
                    m_done = 1'b1;
                    stop   = 1'b1;
                    step();
                    break;
                end
                step();
            end
            if (stop) break;
        end
        Ack = 1'b0;
        if (!go_hold) Go = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Go = 1'b1; Ack = 1'b1;
        step();
        step();
        checks++;
        if (obs_v !== '0) begin
            errors++;
            $display("FAIL reset: got %h want %h", obs_v, {VW{1'b0}});
        end
        Reset = 1'b0; Go = 1'b0; Ack = 1'b0;
        m_to = 1'b0; m_done = 1'b0; m_prog = '0; m_cyc = '0;
        idle_cycles(3, 1'b1);
    endtask

    task automatic test_basic();
        run_batch(10, 20, 5, 1'b0, -1, 0);
        idle_cycles(3, 1'b1);
    endtask

    task automatic test_timeout();
        run_batch(7, 0, 0, 1'b0, -1, 0);
        idle_cycles(4, 1'b1);
        run_batch(3, 4, 5, 1'b0, -1, 0);
        idle_cycles(2, 1'b0);
    endtask

    task automatic test_stale_ack();
        ack_hi = 1'b1;
        run_batch(1, 1, 1, 1'b0, -1, 0);
        ack_hi = 1'b0;
        idle_cycles(2, 1'b0);
    endtask

    task automatic test_ack_at_limit();
        run_batch(TIMEOUT, 2, TIMEOUT, 1'b0, -1, 0);
        idle_cycles(2, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_batch(3, 4, 5, 1'b1, -1, 0);
        run_batch(6, 2, 9, 1'b1, -1, 0);
        idle_cycles(3, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        run_batch(10, 0, 0, 1'b0, 1, 38);
        idle_cycles(6, 1'b1);
    endtask

    task automatic test_random();
        for (int b = 0; b < 8; b++) begin
            run_batch($urandom_range(TIMEOUT + 10, 1), $urandom_range(TIMEOUT + 10, 1),
                      $urandom_range(TIMEOUT + 10, 1), 1'($urandom_range(1, 0)), -1, 0);
            idle_cycles($urandom_range(3, 0), 1'b1);
        end
        idle_cycles(1, 1'b0);
    endtask

    initial begin
        Reset = 1'b1; Go = 1'b0; Ack = 1'b0;
        test_reset();
        test_basic();
        test_timeout();
        test_stale_ack();
        test_ack_at_limit();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
